// File: rtl/fetch_mem_port_pkg.sv
// Shared constants for the fetch memory port: FSM state encodings and default widths.
package fetch_mem_port_pkg;
`include "fetch_defs.vh"

  localparam int unsigned FETCH_ADDR_W = 16;
  localparam int unsigned FETCH_DATA_W = 16;

  // 2'b11 is unused and recovers to IDLE
  localparam logic [1:0] FS_IDLE   = `FS_IDLE;
  localparam logic [1:0] FS_RD_OPC = `FS_RD_OPC;
  localparam logic [1:0] FS_RD_ARG = `FS_RD_ARG;
endpackage

// File: rtl/fetch_defs.vh
// Fetch FSM state encodings shared by the fetch unit, the memory port and the bench.
`ifndef FETCH_DEFS_VH
`define FETCH_DEFS_VH
`define FS_IDLE   2'b00
`define FS_RD_OPC 2'b01
`define FS_RD_ARG 2'b10
`endif

// File: rtl/fetch_line_buf.sv
// One-line {opc,arg} buffer for the fetch port, with hit and sequential-advance comparators.
module fetch_line_buf
  import fetch_mem_port_pkg::*;
#(
  parameter int unsigned ADDR_W = FETCH_ADDR_W,
  parameter int unsigned DATA_W = FETCH_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] pc_in,
  input  logic [ADDR_W-1:0] tgt_pc,
  input  logic              opc_we,
  input  logic [DATA_W-1:0] opc_wdata,
  input  logic              arg_we,
  input  logic [DATA_W-1:0] arg_wdata,
  input  logic              commit,
  input  logic              invalidate,
  output logic              hit,
  output logic              seq,
  output logic              buf_valid,
  output logic [ADDR_W-1:0] buf_pc,
  output logic [DATA_W-1:0] opc_r,
  output logic [DATA_W-1:0] arg_r
);

  logic              buf_valid_r;
  logic [ADDR_W-1:0] buf_pc_r;
  logic [DATA_W-1:0] opc_data_r;
  logic [DATA_W-1:0] arg_data_r;
  logic [ADDR_W-1:0] buf_pc_inc_s;

  // Increment wraps modulo 2**ADDR_W, so pc 0 follows the top address
  assign buf_pc_inc_s = buf_pc_r + ADDR_W'(1);
  assign hit          = buf_valid_r && (buf_pc_r == pc_in);
  assign seq          = (pc_in == buf_pc_inc_s);
  assign buf_valid    = buf_valid_r;
  assign buf_pc       = buf_pc_r;
  assign opc_r        = opc_data_r;
  assign arg_r        = arg_data_r;

  // Valid flag: cleared whenever a fetch starts or is flushed, set when a line completes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_valid_r <= 1'b0;
    end else if (invalidate) begin
      buf_valid_r <= 1'b0;
    end else if (commit) begin
      buf_valid_r <= 1'b1;
    end else begin
      buf_valid_r <= buf_valid_r;
    end
  end

  // Line address and data words
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_pc_r   <= '0;
      opc_data_r <= '0;
      arg_data_r <= '0;
    end else begin
      if (commit) buf_pc_r <= tgt_pc;
      if (opc_we) opc_data_r <= opc_wdata;
      if (arg_we) arg_data_r <= arg_wdata;
    end
  end

endmodule

// File: rtl/fetch_mem_port.sv
// Memory-side responder for the fetch unit: serves {opc,arg} at pc_in from a one-line buffer,
// refilling it from a wait-state SRAM bus and stalling the core through hold.
module fetch_mem_port
  import fetch_mem_port_pkg::*;
#(
  parameter int unsigned ADDR_W   = FETCH_ADDR_W,
  parameter int unsigned DATA_W   = FETCH_DATA_W,
  parameter bit          REUSE_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic [ADDR_W-1:0] pc_in,
  input  logic              flush,
  output logic              hold,
  output logic [DATA_W-1:0] fetch_opc,
  output logic [DATA_W-1:0] fetch_arg,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready
);

  logic [1:0]        state_r, state_nxt_s;
  logic [ADDR_W-1:0] tgt_pc_r, tgt_pc_nxt_s;
  logic              mem_rd_r, mem_rd_nxt_s;
  logic [ADDR_W-1:0] mem_addr_r, mem_addr_nxt_s;

  logic              hit_s, seq_s, buf_valid_s;
  logic [ADDR_W-1:0] buf_pc_s;
  logic [DATA_W-1:0] opc_s, arg_s;
  logic              opc_we_s, arg_we_s, commit_s, inval_s;
  logic [DATA_W-1:0] opc_wdata_s;

  fetch_line_buf #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_line_buf (
    .clk        (clk),
    .rst_n      (rst_n),
    .pc_in      (pc_in),
    .tgt_pc     (tgt_pc_r),
    .opc_we     (opc_we_s),
    .opc_wdata  (opc_wdata_s),
    .arg_we     (arg_we_s),
    .arg_wdata  (mem_rdata),
    .commit     (commit_s),
    .invalidate (inval_s),
    .hit        (hit_s),
    .seq        (seq_s),
    .buf_valid  (buf_valid_s),
    .buf_pc     (buf_pc_s),
    .opc_r      (opc_s),
    .arg_r      (arg_s)
  );

  assign hold      = req && !hit_s;
  assign fetch_opc = opc_s;
  assign fetch_arg = arg_s;
  assign mem_rd    = mem_rd_r;
  assign mem_addr  = mem_addr_r;

  // Next-state and buffer-update decode; flush overrides every state
  always_comb begin
    state_nxt_s    = state_r;
    tgt_pc_nxt_s   = tgt_pc_r;
    mem_rd_nxt_s   = mem_rd_r;
    mem_addr_nxt_s = mem_addr_r;
    opc_we_s       = 1'b0;
    opc_wdata_s    = mem_rdata;
    arg_we_s       = 1'b0;
    commit_s       = 1'b0;
    inval_s        = 1'b0;
    if (flush) begin
      state_nxt_s  = FS_IDLE;
      mem_rd_nxt_s = 1'b0;
      inval_s      = 1'b1;
    end else begin
      case (state_r)
        FS_IDLE: begin
          if (req && !hit_s) begin
            tgt_pc_nxt_s = pc_in;
            inval_s      = 1'b1;
            mem_rd_nxt_s = 1'b1;
            // Sequential advance: the buffered argument word is the new opcode
            if (REUSE_EN && buf_valid_s && seq_s) begin
              opc_we_s       = 1'b1;
              opc_wdata_s    = arg_s;
              mem_addr_nxt_s = pc_in + ADDR_W'(1);
              state_nxt_s    = FS_RD_ARG;
            end else begin
              mem_addr_nxt_s = pc_in;
              state_nxt_s    = FS_RD_OPC;
            end
          end else begin
            state_nxt_s = FS_IDLE;
          end
        end
        FS_RD_OPC: begin
          if (mem_ready) begin
            opc_we_s       = 1'b1;
            mem_addr_nxt_s = tgt_pc_r + ADDR_W'(1);
            state_nxt_s    = FS_RD_ARG;
          end else begin
            state_nxt_s = FS_RD_OPC;
          end
        end
        FS_RD_ARG: begin
          if (mem_ready) begin
            arg_we_s     = 1'b1;
            commit_s     = 1'b1;
            mem_rd_nxt_s = 1'b0;
            state_nxt_s  = FS_IDLE;
          end else begin
            state_nxt_s = FS_RD_ARG;
          end
        end
        default: begin
          state_nxt_s  = FS_IDLE;
          mem_rd_nxt_s = 1'b0;
        end
      endcase
    end
  end

  // FSM and bus registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= FS_IDLE;
      tgt_pc_r   <= '0;
      mem_rd_r   <= 1'b0;
      mem_addr_r <= '0;
    end else begin
      state_r    <= state_nxt_s;
      tgt_pc_r   <= tgt_pc_nxt_s;
      mem_rd_r   <= mem_rd_nxt_s;
      mem_addr_r <= mem_addr_nxt_s;
    end
  end

endmodule

// File: tb/tb_fetch_mem_port.sv
// Directed bench for fetch_mem_port: miss, hit, sequential reuse, wrap, wait states, flush, reset.
module tb_fetch_mem_port;

  logic        clk;
  logic        rst_n;
  logic        req;
  logic [15:0] pc_in;
  logic        flush;
  logic        hold;
  logic [15:0] fetch_opc;
  logic [15:0] fetch_arg;
  logic        mem_rd;
  logic [15:0] mem_addr;
  logic [15:0] mem_rdata;
  logic        mem_ready;

  int n_checks;
  int n_pass;
  int rd_cycles;

  fetch_mem_port #(
    .ADDR_W   (16),
    .DATA_W   (16),
    .REUSE_EN (1'b1)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .pc_in     (pc_in),
    .flush     (flush),
    .hold      (hold),
    .fetch_opc (fetch_opc),
    .fetch_arg (fetch_arg),
    .mem_rd    (mem_rd),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    case (a)
      16'h0100: mem_word = 16'h00A9;
      16'h0101: mem_word = 16'h1234;
      16'h0102: mem_word = 16'h5678;
      16'hFFFF: mem_word = 16'hBEEF;
      16'h0000: mem_word = 16'hC0DE;
      16'h0001: mem_word = 16'h0F0F;
      16'h0200: mem_word = 16'h2222;
      16'h0201: mem_word = 16'h3333;
      default:  mem_word = a ^ 16'h5A5A;
    endcase
  endfunction

  assign mem_rdata = mem_word(mem_addr);

  always @(posedge clk) begin
    if (mem_rd) rd_cycles <= rd_cycles + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks  = 0;
    n_pass    = 0;
    rd_cycles = 0;
    rst_n     = 1'b0;
    req       = 1'b0;
    pc_in     = 16'h0000;
    flush     = 1'b0;
    mem_ready = 1'b1;
    #1;
    check("rst_hold_noreq", {31'd0, hold}, 32'd0);
    check("rst_mem_rd", {31'd0, mem_rd}, 32'd0);
    check("rst_mem_addr", {16'd0, mem_addr}, 32'd0);
    check("rst_opc", {16'd0, fetch_opc}, 32'd0);
    check("rst_arg", {16'd0, fetch_arg}, 32'd0);
    req = 1'b1;
    #1;
    check("rst_hold_req", {31'd0, hold}, 32'd1);
    req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // 1: cold miss at 0x0100, zero wait states
    req   = 1'b1;
    pc_in = 16'h0100;
    #1;
    check("t1_hold_c0", {31'd0, hold}, 32'd1);
    tick();
    check("t1_rd_c1", {31'd0, mem_rd}, 32'd1);
    check("t1_addr_c1", {16'd0, mem_addr}, 32'h0100);
    check("t1_hold_c1", {31'd0, hold}, 32'd1);
    tick();
    check("t1_rd_c2", {31'd0, mem_rd}, 32'd1);
    check("t1_addr_c2", {16'd0, mem_addr}, 32'h0101);
    check("t1_hold_c2", {31'd0, hold}, 32'd1);
    tick();
    check("t1_rd_c3", {31'd0, mem_rd}, 32'd0);
    check("t1_hold_c3", {31'd0, hold}, 32'd0);
    check("t1_opc", {16'd0, fetch_opc}, 32'h00A9);
    check("t1_arg", {16'd0, fetch_arg}, 32'h1234);

    // 2: repeated PC hits, no bus traffic
    rd_cycles = 0;
    #1;
    check("t2_hold_now", {31'd0, hold}, 32'd0);
    tick();
    tick();
    check("t2_no_reads", rd_cycles, 32'd0);
    check("t2_hold_later", {31'd0, hold}, 32'd0);

    // 3: sequential advance reuses arg as opcode, one read
    rd_cycles = 0;
    pc_in     = 16'h0101;
    #1;
    check("t3_hold_c0", {31'd0, hold}, 32'd1);
    tick();
    check("t3_addr_c1", {16'd0, mem_addr}, 32'h0102);
    check("t3_rd_c1", {31'd0, mem_rd}, 32'd1);
    check("t3_hold_c1", {31'd0, hold}, 32'd1);
    check("t3_opc_c1", {16'd0, fetch_opc}, 32'h1234);
    tick();
    check("t3_hold_c2", {31'd0, hold}, 32'd0);
    check("t3_opc", {16'd0, fetch_opc}, 32'h1234);
    check("t3_arg", {16'd0, fetch_arg}, 32'h5678);
    check("t3_one_read", rd_cycles, 32'd1);

    // 4: address wrap, then reuse across the wrap
    pc_in = 16'hFFFF;
    tick();
    check("t4_addr_opc", {16'd0, mem_addr}, 32'hFFFF);
    tick();
    check("t4_addr_arg", {16'd0, mem_addr}, 32'h0000);
    tick();
    check("t4_hold", {31'd0, hold}, 32'd0);
    check("t4_opc", {16'd0, fetch_opc}, 32'hBEEF);
    check("t4_arg", {16'd0, fetch_arg}, 32'hC0DE);
    pc_in = 16'h0000;
    tick();
    check("t4_reuse_addr", {16'd0, mem_addr}, 32'h0001);
    check("t4_reuse_opc", {16'd0, fetch_opc}, 32'hC0DE);
    tick();
    check("t4_reuse_hold", {31'd0, hold}, 32'd0);
    check("t4_reuse_arg", {16'd0, fetch_arg}, 32'h0F0F);

    // 5: wait states in RD_OPC, then flush in RD_ARG with data ready
    pc_in     = 16'h0200;
    mem_ready = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      check("t5_wait_addr", {16'd0, mem_addr}, 32'h0200);
      check("t5_wait_rd", {31'd0, mem_rd}, 32'd1);
      tick();
    end
    check("t5_wait_end_addr", {16'd0, mem_addr}, 32'h0200);
    mem_ready = 1'b1;
    tick();
    check("t5_arg_addr", {16'd0, mem_addr}, 32'h0201);
    check("t5_opc_loaded", {16'd0, fetch_opc}, 32'h2222);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    #1;
    check("t5_flush_rd", {31'd0, mem_rd}, 32'd0);
    check("t5_flush_hold", {31'd0, hold}, 32'd1);
    check("t5_flush_arg_kept", {16'd0, fetch_arg}, 32'h0F0F);
    tick();
    check("t5_refetch_rd", {31'd0, mem_rd}, 32'd1);
    check("t5_refetch_addr", {16'd0, mem_addr}, 32'h0200);
    tick();
    tick();
    check("t5_done_hold", {31'd0, hold}, 32'd0);
    check("t5_done_arg", {16'd0, fetch_arg}, 32'h3333);

    // 6: asynchronous reset during RD_OPC
    pc_in = 16'h0100;
    tick();
    check("t6_pre_rd", {31'd0, mem_rd}, 32'd1);
    mem_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_rd", {31'd0, mem_rd}, 32'd0);
    check("t6_addr", {16'd0, mem_addr}, 32'd0);
    check("t6_opc", {16'd0, fetch_opc}, 32'd0);
    check("t6_arg", {16'd0, fetch_arg}, 32'd0);
    check("t6_hold", {31'd0, hold}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    req   = 1'b0;
    #1;
    check("t6_hold_noreq", {31'd0, hold}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
